seq_divider: RTL and testbench

//  Unsigned iterative integer divider, the inverse of the Dadda multiplier datapath.
//  Non-restoring radix-2: one quotient bit per clock, built on a single prefix add/sub unit.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_prefix_addsub.sv | 51 +++++
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential divider.
// FSM encoding and the iteration-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_prefix_addsub.sv
// Combinational Brent-Kung prefix adder/subtractor.
// sub=1 computes a + ~b + 1; carry-out is dropped.
module prefix_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    localparam int L = (N > 1) ? $clog2(N) : 1;
    localparam int M = 1 << L;

    logic [N-1:0] bx;
    logic [N-1:0] p;
    logic [N-1:0] c;
    logic [M-1:0] gg;
    logic [M-1:0] pp;

    always_comb begin
        bx = sub ? ~b : b;
        p  = a ^ bx;
        gg = '0;
        pp = '0;
        gg[N-1:0] = a & bx;
        pp[N-1:0] = p;
        // carry-in folded into bit 0 so the tree yields true prefix carries
        gg[0] = gg[0] | (pp[0] & sub);
        for (int d = 0; d < L; d++) begin
            for (int i = 0; i < M; i++) begin
                if (((i + 1) % (1 << (d + 1))) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                    pp[i] = pp[i] & pp[i - (1 << d)];
                end
            end
        end
        for (int d = L - 2; d >= 0; d--) begin
            for (int i = 0; i < M; i++) begin
                if (i >= (1 << (d + 1)) &&
                    ((i + 1) % (1 << (d + 1))) == (1 << d)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                    pp[i] = pp[i] & pp[i - (1 << d)];
                end
            end
        end
        c = {gg[N-2:0], sub};
        y = p ^ c;
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned non-restoring radix-2 divider, one quotient bit per clock.
// Single shared add/sub serves both the iterations and the final fix-up.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH:0]  r_q;
    logic [WIDTH:0]  d_q;
    logic [WIDTH-1:0] q_q;
    logic            dbz_q;

    logic [WIDTH:0]  add_a;
    logic [WIDTH:0]  add_y;
    logic            add_sub;
    logic            last_iter;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign ready     = (state_q == IDLE);
    assign busy      = ~ready;

    // RUN: shifted partial remainder, sign picks sub/add; FIX: R + D
    always_comb begin
        add_a   = r_q;
        add_sub = 1'b0;
        if (state_q == RUN) begin
            add_a   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
            add_sub = ~r_q[WIDTH];
        end
    end

    prefix_addsub #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a  (add_a),
        .b  (d_q),
        .sub(add_sub),
        .y  (add_y)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            dbz_q       <= 1'b0;
            valid       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_q   <= dividend;
                        d_q   <= {1'b0, divisor};
                        r_q   <= '0;
                        cnt_q <= '0;
                        dbz_q <= (divisor == '0);
                    end
                end
                RUN: begin
                    r_q   <= add_y;
                    q_q   <= {q_q[WIDTH-2:0], ~add_y[WIDTH]};
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    valid       <= 1'b1;
                    div_by_zero <= dbz_q;
                    if (dbz_q) begin
                        quotient  <= '1;
                        remainder <= q_q;
                    end else begin
                        quotient  <= q_q;
                        remainder <= r_q[WIDTH] ? add_y[WIDTH-1:0]
                                                : r_q[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus random
// operand pairs checked against a plain a/b, a%b reference.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .valid      (valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        e.due = 0;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_valid: got valid=1, expected none (cycle %0d)",
                         cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", 64'(quotient), 64'(mon_e.q));
                chk("remainder", 64'(remainder), 64'(mon_e.r));
                chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
                chk("latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL ready_timeout: got ready=0, expected 1");
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (track) begin
            e     = model(a, b);
            e.due = cyc + ((b == 0) ? 1 : W + 1);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d pending, expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(32'd100, 32'd7, 1);
        issue(32'hFFFF_FFFF, 32'd1, 1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(32'd5, 32'd0, 1);
        issue(32'd9, 32'd3, 1);
        issue(32'd3, 32'd10, 1);
        issue(32'd0, 32'd9, 1);
        issue(32'h8000_0000, 32'h8000_0001, 1);

        // start while busy must not disturb the in-flight divide
        issue(32'd1000, 32'd3, 1);
        repeat (10) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_ignored_start", 64'(busy), 64'd1);
        drain();

        // reset mid-divide aborts without a valid pulse
        issue(32'd1000, 32'd3, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_quotient", 64'(quotient), 64'd0);
        chk("abort_remainder", 64'(remainder), 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_valid", 64'(valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);

        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = W'($urandom_range(1, 255));
                2: b = $urandom >> $urandom_range(0, 31);
                3: b = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> 16);
                default: b = a - W'($urandom_range(0, 2));
            endcase
            issue(a, b, 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
